fetch_sequencer: RTL and testbench

Controller for the instruction-fetch stage of the pipelined RISC-V core. Owns the program counter (PCF), issues instruction-memory requests over a req/ack handshake that tolerates wait states, and loads the IF/ID register (InstrD, PCD, PCPlus4D, ValidD). Applies Execute-stage redirects (PCSrcE/PCTargetE) and hazard-unit stalls (StallF). Lets the fetch stage run from single-cycle or multi-cycle instruction memory with no datapath change.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_watchdog.sv | 45 ++++
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at PCF
        HOLD  = 2'd1,   // fetched word parked in the buffer while decode stalls
        DRAIN = 2'd2    // redirected mid-wait; finishing the stale request
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    // Reset and flush contents of IF/ID: NOP, zero PCs, not valid
    localparam ifid_t IFID_FLUSH = {NOP_INSTR, 32'h0, 32'h0, 1'b0};

endpackage

// File: rtl/fetch_watchdog.sv
// Ack watchdog: counts consecutive unacknowledged request cycles, raises a sticky error.
// Latency: err rises at the edge where the count reaches TIMEOUT_CYCLES.
// Backpressure: none; observation only, never stalls the fetch.
//
// Ports: clk, rst (sync, active high), waiting (req high and no ack this cycle),
//        clear (ack or redirect this cycle), err (sticky until rst).
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic clear,
    output logic err
);

    localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate at the limit so a long outage cannot wrap the counter
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == LIMIT) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns PCF, runs the imem req/ack handshake, loads IF/ID.
// Latency: one instruction per cycle on zero-wait memory, N+1 cycles with N wait states.
// Backpressure: StallF parks a returned word in a one-entry buffer and drops req until release.
//
// Ports: clk, rst (sync, active high); StallF, PCSrcE, PCTargetE from hazard/execute;
//        imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
//        InstrD, PCD, PCPlus4D, ValidD IF/ID outputs; FetchErr sticky watchdog flag.
// Optional feature macro: FETCH_TIMEOUT_EN (ack watchdog; FetchErr tied low otherwise).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchErr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  buf_q, buf_d;     // parked instruction word; its PC is still PCF
    logic [31:0]  redir_q, redir_d; // pending redirect target while draining
    ifid_t        ifid_q, ifid_d;

    logic [31:0]  tgt;
    logic [31:0]  pc_inc;
    logic         ack;

    assign tgt       = PCTargetE & ~32'h3;
    assign pc_inc    = pcf_q + PC_STEP;
    // In DRAIN PCF has not moved yet, so PCF is also the in-flight address
    assign imem_req  = (state_q != HOLD) && !rst;
    assign imem_addr = pcf_q;
    assign ack       = imem_ack && imem_req;

    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        buf_d   = buf_q;
        redir_d = redir_q;
        ifid_d  = ifid_q;

        case (state_q)
            FETCH: begin
                if (PCSrcE) begin
                    ifid_d = IFID_FLUSH;
                    if (ack) begin
                        pcf_d = tgt;
                    end else begin
                        // Memory may not accept a new address mid-request
                        redir_d = tgt;
                        state_d = DRAIN;
                    end
                end else if (ack) begin
                    if (StallF) begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        ifid_d = {imem_rdata, pcf_q, pc_inc, 1'b1};
                        pcf_d  = pc_inc;
                    end
                end
            end

            HOLD: begin
                if (PCSrcE) begin
                    ifid_d  = IFID_FLUSH;
                    pcf_d   = tgt;
                    state_d = FETCH;
                end else if (!StallF) begin
                    ifid_d  = {buf_q, pcf_q, pc_inc, 1'b1};
                    pcf_d   = pc_inc;
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                if (PCSrcE) begin
                    redir_d = tgt;
                    ifid_d  = IFID_FLUSH;
                end
                if (ack) begin
                    // Stale word is dropped; the newest redirect wins
                    pcf_d   = PCSrcE ? tgt : redir_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pcf_q   <= RESET_PC;
            buf_q   <= '0;
            redir_q <= '0;
            ifid_q  <= IFID_FLUSH;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            buf_q   <= buf_d;
            redir_q <= redir_d;
            ifid_q  <= ifid_d;
        end
    end

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

`ifdef FETCH_TIMEOUT_EN
    logic wd_waiting;
    logic wd_clear;

    assign wd_waiting = imem_req && !imem_ack;
    assign wd_clear   = ack || PCSrcE;

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .waiting (wd_waiting),
        .clear   (wd_clear),
        .err     (FetchErr)
    );
`else
    assign FetchErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed runs plus a cycle model.
// Latency: n/a.
// Backpressure: memory model with programmable wait states and a block switch.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          TO     = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        imem_req, imem_ack, ValidD, FetchErr;
    logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;

    logic        w_req, w_valid, w_err;
    logic [31:0] w_addr, w_instr, w_pcd, w_pcp4;

    int nwait = 0;
    bit mem_block = 1'b0;
    int mem_cnt = 0;

    int tests = 0;
    int fails = 0;

    // Memory returns the address as data after nwait stall cycles
    assign imem_ack   = imem_req && !mem_block && (mem_cnt >= nwait);
    assign imem_rdata = imem_addr;
    always @(posedge clk) begin
        if (imem_req === 1'b1 && imem_ack !== 1'b1) mem_cnt <= mem_cnt + 1;
        else                                          mem_cnt <= 0;
    end

    fetch_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchErr(FetchErr)
    );

    // Second instance starting near the top of the address space, zero-wait memory
    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .TIMEOUT_CYCLES(TO)) dut_w (
        .clk(clk), .rst(rst), .StallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_addr),
        .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pcp4), .ValidD(w_valid), .FetchErr(w_err)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks: next address to fetch, whether a word is parked, whether a stale
    // request is being drained (and where to go after), plus expected IF/ID.
    bit          m_init = 1'b0;
    bit          m_held, m_drain, e_valid, e_err;
    logic [31:0] m_pc, m_buf, m_tgt, e_instr, e_pcd, e_pcp4;
    int          m_wait;
    bit          m_ack;
    logic [31:0] m_new;

    always @(negedge clk) begin
        if (m_init) begin
            chk1("m_req", imem_req, !rst && !m_held);
            if (!rst && !m_held) chk32("m_addr", imem_addr, m_pc);
            chk32("m_InstrD", InstrD, e_instr);
            chk32("m_PCD", PCD, e_pcd);
            chk32("m_PCPlus4D", PCPlus4D, e_pcp4);
            chk1("m_ValidD", ValidD, e_valid);
            chk1("m_FetchErr", FetchErr, e_err);
        end
        if (rst) begin
            m_init = 1'b1;
            m_pc = RST_PC; m_held = 0; m_drain = 0; m_buf = 0; m_tgt = 0; m_wait = 0;
            e_instr = NOP; e_pcd = 0; e_pcp4 = 0; e_valid = 0; e_err = 0;
        end else if (m_init) begin
            m_ack = (imem_ack === 1'b1) && !m_held;
            m_new = PCTargetE & 32'hFFFF_FFFC;
            if (WD) begin
                if (m_ack || PCSrcE) m_wait = 0;
                else if (!m_held)    m_wait = m_wait + 1;
                if (m_wait >= TO) e_err = 1;
            end
            if (PCSrcE) begin
                e_instr = NOP; e_pcd = 0; e_pcp4 = 0; e_valid = 0;
            end
            if (m_held) begin
                if (PCSrcE) begin
                    m_held = 0; m_pc = m_new;
                end else if (!StallF) begin
                    e_instr = m_buf; e_pcd = m_pc; e_pcp4 = m_pc + 4; e_valid = 1;
                    m_pc = m_pc + 4; m_held = 0;
                end
            end else if (m_drain) begin
                if (PCSrcE) m_tgt = m_new;
                if (m_ack) begin
                    m_pc = m_tgt; m_drain = 0;
                end
            end else if (PCSrcE) begin
                if (m_ack) m_pc = m_new;
                else begin m_drain = 1; m_tgt = m_new; end
            end else if (m_ack) begin
                if (StallF) begin
                    m_held = 1; m_buf = m_pc;
                end else begin
                    e_instr = m_pc; e_pcd = m_pc; e_pcp4 = m_pc + 4; e_valid = 1;
                    m_pc = m_pc + 4;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset(input int nw, input bit blk);
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        nwait = nw; mem_block = blk;
        step(); step();
        rst = 1'b0;
    endtask

    logic [31:0] wexp [4];
    logic [15:0] stall_pat;

    initial begin
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        stall_pat = 16'b0011_0000_1110_0100;

        // Reset state and zero-wait streaming (both instances)
        do_reset(0, 0);
        at_neg();
        chk1("rst_valid", ValidD, 1'b0);
        chk32("rst_instr", InstrD, NOP);
        chk1("rst_req", imem_req, 1'b1);
        chk32("rst_addr", imem_addr, 32'h0);
        chk1("rst_err", FetchErr, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(); at_neg();
            chk32("zw_pcd", PCD, 32'(4 * i));
            chk32("zw_instr", InstrD, 32'(4 * i));
            chk1("zw_valid", ValidD, 1'b1);
            chk32("wrap_pcd", w_pcd, wexp[i]);
        end

        // Two wait states: address held three cycles, IF/ID updates every third
        do_reset(2, 0);
        at_neg();  chk32("ws_addr0", imem_addr, 32'h0);
        step(); at_neg(); chk32("ws_addr1", imem_addr, 32'h0); chk1("ws_valid1", ValidD, 1'b0);
        step(); at_neg(); chk32("ws_addr2", imem_addr, 32'h0); chk1("ws_ack2", imem_ack, 1'b1);
        step(); at_neg(); chk32("ws_pcd3", PCD, 32'h0); chk32("ws_addr3", imem_addr, 32'h4);
        step(); at_neg(); chk32("ws_pcd4", PCD, 32'h0);
        step(); at_neg(); chk32("ws_pcd5", PCD, 32'h0);
        step(); at_neg(); chk32("ws_pcd6", PCD, 32'h4); chk32("ws_instr6", InstrD, 32'h4);

        // Zero-wait redirect
        do_reset(0, 0);
        step(); step();
        PCSrcE = 1'b1; PCTargetE = 32'h20;
        step();
        PCSrcE = 1'b0;
        at_neg(); chk1("rz_valid", ValidD, 1'b0); chk32("rz_instr", InstrD, NOP);
        chk32("rz_addr", imem_addr, 32'h20);
        step(); at_neg(); chk32("rz_pcd", PCD, 32'h20); chk1("rz_valid2", ValidD, 1'b1);

        // Redirect during wait state 1 of 3: old fetch drains, then target
        do_reset(3, 0);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0;
        at_neg(); chk32("dr_old_addr", imem_addr, 32'h0); chk1("dr_req", imem_req, 1'b1);
        step(); step();
        at_neg(); chk32("dr_new_addr", imem_addr, 32'h40); chk1("dr_valid", ValidD, 1'b0);

        // Second redirect during the drain wins; low target bits are ignored
        do_reset(3, 0);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        PCTargetE = 32'h83;
        step();
        PCSrcE = 1'b0;
        step();
        at_neg(); chk32("dr2_addr", imem_addr, 32'h80);
        step(); step(); step(); step();
        at_neg(); chk32("dr2_pcd", PCD, 32'h80); chk32("dr2_instr", InstrD, 32'h80);

        // Stall across an ack near the top of the address space
        do_reset(0, 0);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
        step();
        PCSrcE = 1'b0;
        step();
        StallF = 1'b1;
        at_neg(); chk32("st_pcd2", PCD, 32'hFFFF_FFF8); chk32("st_addr2", imem_addr, 32'hFFFF_FFFC);
        step(); at_neg(); chk1("st_req3", imem_req, 1'b0); chk32("st_pcd3", PCD, 32'hFFFF_FFF8);
        step(); at_neg(); chk32("st_pcd4", PCD, 32'hFFFF_FFF8);
        step();
        StallF = 1'b0;
        at_neg(); chk1("st_req5", imem_req, 1'b0);
        step(); at_neg();
        chk32("st_pcd6", PCD, 32'hFFFF_FFFC); chk32("st_instr6", InstrD, 32'hFFFF_FFFC);
        chk32("st_pcp4_6", PCPlus4D, 32'h0); chk32("st_addr6", imem_addr, 32'h0);
        step(); at_neg(); chk32("st_pcd7", PCD, 32'h0); chk32("st_pcp4_7", PCPlus4D, 32'h4);

        // Watchdog with ack held low, then reset mid-request
        do_reset(0, 1);
        at_neg(); chk1("to_err0", FetchErr, 1'b0);
        step(); step(); step();
        at_neg(); chk1("to_err3", FetchErr, 1'b0);
        step(); at_neg(); chk1("to_err4", FetchErr, WD);
        step(); step(); at_neg(); chk1("to_err6", FetchErr, WD); chk32("to_addr6", imem_addr, 32'h0);
        do_reset(0, 0);
        at_neg(); chk1("to_err_rst", FetchErr, 1'b0);

        // Mixed stalls and redirects on one-wait memory, checked by the model
        do_reset(1, 0);
        for (int i = 0; i < 64; i++) begin
            StallF = stall_pat[i % 16];
            PCSrcE = ((i % 13) == 5) || ((i % 17) == 9);
            PCTargetE = 32'h100 + 32'(i * 16) + 32'(i % 4);
            step();
        end
        StallF = 1'b0; PCSrcE = 1'b0;
        step(); step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
